twiddle_phase_gen: RTL and testbench

- Sequential phase-address generator sitting directly upstream of the cosine LUT wrapper in each radix-2 single-delay-feedback (SDF) DIF FFT stage.
- Counts samples within an FFT frame and emits, per sample, the 8-bit phase index for the cosine lookup and the quarter-turn-shifted index for the sine lookup.
- Also emits a bypass flag for the upper butterfly half (twiddle = 1) and frame markers.
- Valid/ready handshake on both sides, one output register stage.

---
 rtl/twiddle_phase_gen_pkg.sv | 17 +
 rtl/twiddle_phase_map.sv | 29 ++
 rtl/twiddle_phase_gen.sv | 103 ++++++++++
 tb/tb_twiddle_phase_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_phase_gen_pkg.sv
// Shared constants, FSM state type and shift helper for the SDF FFT twiddle path.
package twiddle_phase_gen_pkg;

    localparam int PHI_W   = 8;
    localparam int QUARTER = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Left shift that scales an in-half offset onto the 2^PHI_W-entry circle.
    function automatic int stage_shift(input int n_log2, input int stage);
        return stage + PHI_W - n_log2;
    endfunction

endpackage

// File: rtl/twiddle_phase_map.sv
// Combinational map from in-frame sample index to cos/sin phase indices and bypass flag.
// Latency: none (pure combinational).
// Backpressure: not applicable; caller registers the result.
module twiddle_phase_map
    import twiddle_phase_gen_pkg::*;
#(
    parameter int N_LOG2 = 8,
    parameter int STAGE  = 0
) (
    input  logic [N_LOG2-1:0] k,
    output logic [PHI_W-1:0]  phi_cos,
    output logic [PHI_W-1:0]  phi_sin,
    output logic              tw_bypass
);

    localparam int LW = N_LOG2 - STAGE;
    localparam int SH = stage_shift(N_LOG2, STAGE);

    logic [31:0] off;

    // The top bit of j = k mod L selects the half; the bits below it are j - H.
    always_comb begin
        off       = 32'(k) & ((32'd1 << (LW - 1)) - 32'd1);
        tw_bypass = ~k[LW-1];
        phi_cos   = tw_bypass ? '0 : PHI_W'(off << SH);
        phi_sin   = phi_cos - PHI_W'(QUARTER);
    end

endmodule

// File: rtl/twiddle_phase_gen.sv
// Per-sample twiddle phase generator for a radix-2 SDF DIF FFT stage.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = RUN && (!out_valid || out_ready); outputs hold while stalled.
module twiddle_phase_gen #(
    parameter int N_LOG2     = 8,
    parameter int STAGE      = 0,
    parameter int PHI_W      = 8,
    parameter bit SYNC_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PHI_W-1:0]  phi_cos,
    output logic [PHI_W-1:0]  phi_sin,
    output logic              tw_bypass,
    output logic [N_LOG2-1:0] sample_idx,
    output logic              sof,
    output logic              eof
);

    import twiddle_phase_gen_pkg::*;

    localparam state_t RST_STATE = SYNC_START ? IDLE : RUN;

    state_t            state;
    state_t            state_nxt;
    logic [N_LOG2-1:0] k;
    logic [N_LOG2-1:0] k_src;
    logic              accept;
    logic [PHI_W-1:0]  map_cos;
    logic [PHI_W-1:0]  map_sin;
    logic              map_byp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && sync) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        in_ready = (state == RUN) && (!out_valid || out_ready);
    end

    assign accept = in_valid && in_ready;
    // A sync in the accept cycle realigns the sample being taken, not the next one.
    assign k_src  = sync ? '0 : k;

    twiddle_phase_map #(
        .N_LOG2 (N_LOG2),
        .STAGE  (STAGE)
    ) u_map (
        .k         (k_src),
        .phi_cos   (map_cos),
        .phi_sin   (map_sin),
        .tw_bypass (map_byp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (accept) begin
            k <= k_src + N_LOG2'(1);
        end else if (sync) begin
            k <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            phi_cos    <= '0;
            phi_sin    <= '0;
            tw_bypass  <= 1'b0;
            sample_idx <= '0;
            sof        <= 1'b0;
            eof        <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            phi_cos    <= map_cos;
            phi_sin    <= map_sin;
            tw_bypass  <= map_byp;
            sample_idx <= k_src;
            sof        <= (k_src == '0);
            eof        <= (k_src == '1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twiddle_phase_gen.sv
// Drives four differently-parameterised generators with shared stimulus against a spec-level model.
module tb_twiddle_phase_gen;

    localparam int NI = 4;

    function automatic int cfg_n(input int i);
        case (i)
            0: return 8;
            1: return 8;
            2: return 6;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 1;
            1: return 0;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_ss(input int i);
        return (i == 3) ? 0 : 1;
    endfunction

    logic clk;
    logic rst;
    logic sync;
    logic in_valid;
    logic out_ready;

    logic       ir    [NI];
    logic       ov    [NI];
    logic       byp   [NI];
    logic       sof_a [NI];
    logic       eof_a [NI];
    logic [7:0] pc    [NI];
    logic [7:0] ps    [NI];
    logic [7:0] sidx  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int GN = cfg_n(g);
        localparam int GS = cfg_s(g);
        localparam bit GSS = (cfg_ss(g) != 0);
        logic [GN-1:0] sidx_w;

        twiddle_phase_gen #(
            .N_LOG2     (GN),
            .STAGE      (GS),
            .PHI_W      (8),
            .SYNC_START (GSS)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sync       (sync),
            .in_valid   (in_valid),
            .in_ready   (ir[g]),
            .out_valid  (ov[g]),
            .out_ready  (out_ready),
            .phi_cos    (pc[g]),
            .phi_sin    (ps[g]),
            .tw_bypass  (byp[g]),
            .sample_idx (sidx_w),
            .sof        (sof_a[g]),
            .eof        (eof_a[g])
        );

        assign sidx[g] = 8'(sidx_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntot  = 0;
    int npass = 0;

    // Reference state: running flag, next k, held-output flag/k, outputs-still-at-reset flag.
    int m_run  [NI];
    int m_k    [NI];
    int m_vld  [NI];
    int m_kout [NI];
    int m_rz   [NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void ref_phase(input int n, input int s, input int k,
                                      output int c, output int sn, output int b);
        int l, h, j;
        l = 1 << (n - s);
        h = l / 2;
        j = k % l;
        if (j < h) begin
            b = 1;
            c = 0;
        end else begin
            b = 0;
            c = (((j - h) << s) << (8 - n)) % 256;
        end
        sn = (c + 192) % 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_run[i]  = (cfg_ss(i) == 0) ? 1 : 0;
            m_k[i]    = 0;
            m_vld[i]  = 0;
            m_kout[i] = 0;
            m_rz[i]   = 1;
        end
    endtask

    task automatic model_edge(input bit v, input bit r, input bit sy);
        int rdy, ks;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            rdy = (m_run[i] != 0 && (m_vld[i] == 0 || r)) ? 1 : 0;
            if (m_run[i] == 0) begin
                if (sy) begin
                    m_run[i] = 1;
                    m_k[i]   = 0;
                end
            end else begin
                ks = sy ? 0 : m_k[i];
                if (v && rdy != 0) begin
                    m_kout[i] = ks;
                    m_vld[i]  = 1;
                    m_rz[i]   = 0;
                    m_k[i]    = (ks + 1) % (1 << cfg_n(i));
                end else begin
                    if (sy) m_k[i] = 0;
                    if (r) m_vld[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input bit r);
        int ec, es, eb, eir;
        for (int i = 0; i < NI; i++) begin
            eir = (m_run[i] != 0 && (m_vld[i] == 0 || r)) ? 1 : 0;
            chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(eir));
            chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m_vld[i]));
            if (m_vld[i] != 0) begin
                ref_phase(cfg_n(i), cfg_s(i), m_kout[i], ec, es, eb);
                chk($sformatf("phi_cos[%0d] k=%0d", i, m_kout[i]), 32'(pc[i]), 32'(ec));
                chk($sformatf("phi_sin[%0d] k=%0d", i, m_kout[i]), 32'(ps[i]), 32'(es));
                chk($sformatf("bypass[%0d] k=%0d", i, m_kout[i]), 32'(byp[i]), 32'(eb));
                chk($sformatf("sample_idx[%0d]", i), 32'(sidx[i]), 32'(m_kout[i]));
                chk($sformatf("sof[%0d] k=%0d", i, m_kout[i]), 32'(sof_a[i]), 32'(m_kout[i] == 0));
                chk($sformatf("eof[%0d] k=%0d", i, m_kout[i]), 32'(eof_a[i]),
                    32'(m_kout[i] == (1 << cfg_n(i)) - 1));
            end else if (m_rz[i] != 0) begin
                chk($sformatf("rst_phi_cos[%0d]", i), 32'(pc[i]), 32'd0);
                chk($sformatf("rst_phi_sin[%0d]", i), 32'(ps[i]), 32'd0);
                chk($sformatf("rst_bypass[%0d]", i), 32'(byp[i]), 32'd0);
                chk($sformatf("rst_sample_idx[%0d]", i), 32'(sidx[i]), 32'd0);
                chk($sformatf("rst_sof[%0d]", i), 32'(sof_a[i]), 32'd0);
                chk($sformatf("rst_eof[%0d]", i), 32'(eof_a[i]), 32'd0);
            end
        end
        // Hand-derived spot values for the headline cases.
        if (m_vld[0] != 0 && m_kout[0] == 64) chk("s1_k64_bypass", 32'(byp[0]), 32'd0);
        if (m_vld[0] != 0 && m_kout[0] == 65) chk("s1_k65_cos", 32'(pc[0]), 32'd2);
        if (m_vld[0] != 0 && m_kout[0] == 65) chk("s1_k65_sin", 32'(ps[0]), 32'd194);
        if (m_vld[0] != 0 && m_kout[0] == 127) chk("s1_k127_cos", 32'(pc[0]), 32'd126);
        if (m_vld[0] != 0 && m_kout[0] == 127) chk("s1_k127_sin", 32'(ps[0]), 32'd62);
        if (m_vld[0] != 0 && m_kout[0] == 10) chk("s1_k10_sin", 32'(ps[0]), 32'd192);
        if (m_vld[1] != 0 && m_kout[1] == 128) chk("s0_k128_cos", 32'(pc[1]), 32'd0);
        if (m_vld[1] != 0 && m_kout[1] == 255) chk("s0_k255_cos", 32'(pc[1]), 32'd127);
        if (m_vld[1] != 0 && m_kout[1] == 255) chk("s0_k255_sin", 32'(ps[1]), 32'd63);
        if (m_vld[1] != 0 && m_kout[1] == 255) chk("s0_k255_eof", 32'(eof_a[1]), 32'd1);
        if (m_vld[2] != 0 && m_kout[2] == 15) chk("n6s2_k15_cos", 32'(pc[2]), 32'd112);
        if (m_vld[2] != 0 && m_kout[2] == 15) chk("n6s2_k15_sin", 32'(ps[2]), 32'd48);
    endtask

    task automatic step(input bit v, input bit r, input bit sy);
        in_valid  = v;
        out_ready = r;
        sync      = sy;
        @(negedge clk);
        check_all(r);
        @(posedge clk);
        model_edge(v, r, sy);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        sync      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        step(0, 0, 0);
        step(0, 1, 0);
        rst = 1'b0;

        // Sync-start instances stay idle until sync; the free-running one streams.
        for (int n = 0; n < 3; n++) step(1, 1, 0);
        step(0, 1, 1);
        for (int n = 0; n < 300; n++) step(1, 1, 0);

        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0);

        // Backpressure: three stalled cycles after an accept.
        step(1, 1, 0);
        for (int n = 0; n < 3; n++) begin
            step(1, 0, 0);
            chk("stall_in_ready", 32'(ir[0]), 32'd0);
        end
        step(1, 1, 0);
        step(1, 1, 0);

        // Mid-frame sync together with an accept at k=37.
        for (int n = 0; n < 300 && m_k[0] != 37; n++) step(1, 1, 0);
        step(1, 1, 1);
        chk("sync_sample_idx", 32'(sidx[0]), 32'd0);
        chk("sync_sof", 32'(sof_a[0]), 32'd1);
        step(1, 1, 0);
        chk("post_sync_sample_idx", 32'(sidx[0]), 32'd1);

        // Asynchronous reset in the middle of a cycle at k=200.
        for (int n = 0; n < 300 && m_k[1] != 200; n++) step(1, 1, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("async_rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
        model_reset();
        step(1, 1, 0);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step(1, 1, 0);
            chk("idle_after_rst_in_ready", 32'(ir[0]), 32'd0);
        end
        step(1, 1, 1);
        for (int n = 0; n < 20; n++) step(1, $urandom_range(0, 1) != 0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
